// File: rtl/interboard_receiver.sv
// Receive endpoint of the inter-board link: synchronizes the peer's 4-phase
// Request/Ack handshake, collects four 6-bit words and emits decoded fields.
module interboard_receiver #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [3:0] RST_MSG_TYPE   = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic       interboard_rst,
  output logic [3:0] interboard_msg_type,
  output logic       interboard_move_dir,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic [5:0] interboard_card,
  output logic [2:0] interboard_sel_len,
  output logic       rx_busy,
  output logic       rx_error,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_REQ = 2'd0,
    ACK      = 2'd1,
    EMIT     = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  to_cnt;
  logic [5:0]        words [4];

  logic [SYNC_STAGES-1:0] req_sync;
  logic [5:0]             data_sync [SYNC_STAGES];
  logic                   req_s;
  logic [5:0]             data_s;

  logic capture, release_w, do_emit, tick, timeout;

  // Handshake: the peer raises Request_in with data already stable; we capture
  // once, raise Ack_out, and hold it until the peer drops Request_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      req_sync     <= {req_sync[SYNC_STAGES-2:0], Request_in};
      data_sync[0] <= inter_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_REQ;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    release_w = 1'b0;
    do_emit   = 1'b0;
    tick      = 1'b0;
    timeout   = 1'b0;
    case (state)
      WAIT_REQ: begin
        if (req_s) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end else if (idx != 2'd0) begin
          if (to_cnt == CNT_LAST) timeout = 1'b1;
          else                    tick    = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          release_w = 1'b1;
          state_nxt = (idx == 2'd3) ? EMIT : WAIT_REQ;
        end
      end
      EMIT: begin
        do_emit   = 1'b1;
        state_nxt = WAIT_REQ;
      end
      default: state_nxt = WAIT_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx                 <= '0;
      to_cnt              <= '0;
      Ack_out             <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_rst      <= 1'b0;
      rx_error            <= 1'b0;
      interboard_msg_type <= '0;
      interboard_move_dir <= 1'b0;
      interboard_block_x  <= '0;
      interboard_block_y  <= '0;
      interboard_card     <= '0;
      interboard_sel_len  <= '0;
      for (int i = 0; i < 4; i++) words[i] <= '0;
    end else begin
      interboard_en  <= 1'b0;
      interboard_rst <= 1'b0;
      rx_error       <= 1'b0;
      to_cnt         <= tick ? to_cnt + 1'b1 : '0;
      if (capture) begin
        words[idx] <= data_s;
        Ack_out    <= 1'b1;
      end
      if (release_w) begin
        Ack_out <= 1'b0;
        idx     <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
      end
      // Abort drops the partial packet; the slots are simply overwritten later.
      if (timeout) begin
        idx      <= '0;
        rx_error <= 1'b1;
      end
      if (do_emit) begin
        interboard_en       <= 1'b1;
        interboard_rst      <= (words[0][5:2] == RST_MSG_TYPE);
        interboard_msg_type <= words[0][5:2];
        interboard_move_dir <= words[0][1];
        interboard_block_x  <= words[1][5:1];
        interboard_block_y  <= words[2][5:3];
        interboard_sel_len  <= words[2][2:0];
        interboard_card     <= words[3];
      end
    end
  end

  // Reserved bits of w0 and w1 carry no information.
  logic unused_reserved;
  assign unused_reserved = words[0][0] ^ words[1][0];

  assign rx_busy   = (idx != 2'd0) || (state == ACK);
  assign state_dbg = state;

endmodule

// File: tb/tb_interboard_receiver.sv
// Randomized bench for interboard_receiver: a peer-side driver, a negedge
// monitor and a field-level reference model with an expected-packet queue.
module tb_interboard_receiver;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = '0;
  logic       Ack_out, interboard_en, interboard_rst, interboard_move_dir;
  logic       rx_busy, rx_error;
  logic [3:0] interboard_msg_type;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y, interboard_sel_len;
  logic [5:0] interboard_card;
  logic [1:0] state_dbg;

  interboard_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .RST_MSG_TYPE(4'd15)) dut (
    .clk(clk), .rst(rst), .Request_in(Request_in), .inter_data_in(inter_data_in),
    .Ack_out(Ack_out), .interboard_en(interboard_en), .interboard_rst(interboard_rst),
    .interboard_msg_type(interboard_msg_type), .interboard_move_dir(interboard_move_dir),
    .interboard_block_x(interboard_block_x), .interboard_block_y(interboard_block_y),
    .interboard_card(interboard_card), .interboard_sel_len(interboard_sel_len),
    .rx_busy(rx_busy), .rx_error(rx_error), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;
  int          en_cnt = 0;
  int          err_cnt = 0;
  int          ack_rise = 0;
  logic        ack_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Field-level model: {rst_flag, msg_type, move_dir, block_x, block_y, card, sel_len}
  function automatic logic [31:0] model(input logic [5:0] w0, w1, w2, w3);
    int msg, dir, bx, by, sel, card, rflag;
    msg   = int'(w0) / 4;
    dir   = (int'(w0) / 2) % 2;
    bx    = int'(w1) / 2;
    by    = int'(w2) / 8;
    sel   = int'(w2) % 8;
    card  = int'(w3);
    rflag = (msg == 15) ? 1 : 0;
    return 32'(rflag * (1 << 22) + msg * (1 << 18) + dir * (1 << 17) + bx * (1 << 12)
               + by * (1 << 9) + card * (1 << 3) + sel);
  endfunction

  function automatic logic [31:0] observed();
    return {9'd0, interboard_rst, interboard_msg_type, interboard_move_dir, interboard_block_x,
            interboard_block_y, interboard_card, interboard_sel_len};
  endfunction

  function automatic logic [31:0] all_outputs();
    return {5'd0, Ack_out, interboard_en, interboard_rst, rx_busy, rx_error, interboard_msg_type,
            interboard_move_dir, interboard_block_x, interboard_block_y, interboard_card,
            interboard_sel_len};
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (Ack_out && !ack_prev) ack_rise++;
    ack_prev = Ack_out;
    if (rx_error) err_cnt++;
    if (interboard_rst) check_val("rst_with_en", interboard_en, 1);
    if (interboard_en) begin
      en_cnt++;
      check_val("en_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("packet_fields", observed(), exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (Ack_out !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (Ack_out !== lvl) check_val(lvl ? "ack_rise_wait" : "ack_fall_wait", Ack_out, lvl);
  endtask

  task automatic send_word(input logic [5:0] w, input int hold, input int gap);
    int drops = 0;
    repeat (gap) @(negedge clk);
    inter_data_in = w;
    @(negedge clk);
    Request_in = 1'b1;
    wait_ack(1'b1);
    repeat (hold) begin
      @(negedge clk);
      if (!Ack_out) drops++;
    end
    if (hold > 0) check_val("ack_held", drops, 0);
    Request_in = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic send_packet(input logic [5:0] w0, w1, w2, w3, input int gap);
    last_exp = model(w0, w1, w2, w3);
    exp_q.push_back(last_exp);
    send_word(w0, 0, gap);
    send_word(w1, 0, gap);
    send_word(w2, 0, gap);
    send_word(w3, 0, gap);
  endtask

  task automatic wait_en(input int target);
    for (int i = 0; i < 50 && en_cnt < target; i++) @(negedge clk);
    check_val("en_count", en_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a0, e0, n;
    logic [5:0] r0, r1, r2, r3;

    // reset state
    repeat (3) @(negedge clk);
    check_val("reset_outputs", all_outputs(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // normal packet
    a0 = ack_rise; e0 = en_cnt;
    send_packet(6'h3A, 6'h2A, 6'h2B, 6'h05, 2);
    wait_en(e0 + 1);
    repeat (5) @(negedge clk);
    check_val("normal_ack_pairs", ack_rise - a0, 4);
    check_val("normal_single_en", en_cnt - e0, 1);
    check_val("normal_msg_type", interboard_msg_type, 14);
    check_val("normal_move_dir", interboard_move_dir, 1);
    check_val("normal_block_x", interboard_block_x, 21);
    check_val("normal_block_y", interboard_block_y, 5);
    check_val("normal_sel_len", interboard_sel_len, 3);
    check_val("normal_card", interboard_card, 5);

    // reset-type message
    e0 = en_cnt;
    send_packet(6'h3C, 6'h00, 6'h00, 6'h00, 1);
    wait_en(e0 + 1);
    check_val("rstmsg_type", interboard_msg_type, 15);

    // request held for 500 cycles on w0
    r0 = 6'($urandom_range(0, 63)); r1 = 6'($urandom_range(0, 63));
    r2 = 6'($urandom_range(0, 63)); r3 = 6'($urandom_range(0, 63));
    a0 = ack_rise; e0 = en_cnt;
    last_exp = model(r0, r1, r2, r3);
    exp_q.push_back(last_exp);
    send_word(r0, 500, 1);
    check_val("held_single_capture", ack_rise - a0, 1);
    check_val("held_busy", rx_busy, 1);
    send_word(r1, 0, 1);
    send_word(r2, 0, 1);
    send_word(r3, 0, 1);
    wait_en(e0 + 1);

    // timeout after two words
    e0 = en_cnt;
    send_word(6'($urandom_range(0, 63)), 0, 1);
    send_word(6'($urandom_range(0, 63)), 0, 1);
    check_val("partial_busy", rx_busy, 1);
    n = 0;
    while (!rx_error && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("timeout_window", 32'(n >= TO - 1 && n <= TO + 1), 1);
    check_val("timeout_busy_drop", rx_busy, 0);
    @(negedge clk);
    check_val("timeout_error_pulse", rx_error, 0);
    check_val("timeout_no_en", en_cnt, e0);
    check_val("fields_hold", observed() & 32'h3FFFFF, last_exp & 32'h3FFFFF);
    send_packet(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1);
    wait_en(e0 + 1);

    // back-to-back packets, request reasserted one cycle after Ack falls
    e0 = en_cnt;
    send_packet(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
    send_packet(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
    wait_en(e0 + 2);

    // reset asserted while acknowledging w2
    e0 = en_cnt;
    send_word(6'h3C, 0, 1);
    send_word(6'h15, 0, 1);
    inter_data_in = 6'h2B;
    @(negedge clk);
    Request_in = 1'b1;
    wait_ack(1'b1);
    #2 rst = 1'b0;
    #1 check_val("midreset_outputs", all_outputs(), 0);
    Request_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midreset_no_en", en_cnt, e0);
    send_packet(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1);
    wait_en(e0 + 1);

    // random packets
    for (int k = 0; k < 20; k++) begin
      r0 = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) r0[5:2] = 4'd15;
      e0 = en_cnt;
      send_packet(r0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  6'($urandom_range(0, 63)), int'($urandom_range(0, 4)));
      wait_en(e0 + 1);
    end

    repeat (10) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    check_val("error_pulses", err_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
